mp_add_serial: RTL
==================

// Module: mp_add_serial
// PURPOSE
//  Word-serial multi-precision adder: Z = X + Y over N_WORDS x W-bit words, LSW first.
//  Companion of the word-serial subtractor in the big-number arithmetic datapath (RSA/modexp path).
//  Carry is propagated cycle-to-cycle; input uses a valid/ready handshake and output is registered.
//  Full 2048-bit result streams out one word per cycle with no bubbles, plus a final carry-out.
// PARAMETERS
//  W        32   word width in bits
//  N_WORDS  64   words per operand (64 x 32 = 2048 bits)
//  CW       7    word counter width, $clog2(N_WORDS)+1
// PORTS
//  iClk     in   1  clock; all state updates on rising edge
//  iRst_n   in   1  asynchronous reset, active low
//  iEnable  in   1  synchronous enable; low = abort and clear to IDLE
//  iStart   in   1  one-cycle pulse; starts a new operation from IDLE
//  iX       in   W  operand X word
//  iY       in   W  operand Y word
//  iValid   in   1  iX/iY word valid
//  oReady   out  1  block accepts the input word this cycle
//  oZ       out  W  sum word, registered
//  oValid   out  1  oZ valid
//  iReady   in   1  downstream accepts oZ
//  oCarry   out  1  final carry-out of the MSW; valid from oFinish until the next iStart
//  oBusy    out  1  high from iStart acceptance until oFinish
//  oFinish  out  1  one-cycle pulse after the last word has been taken downstream
// BEHAVIOUR
//  - Reset (iRst_n=0): state=IDLE, carry=0, count=0, oZ=0, oValid=0, oReady=0, oCarry=0, oBusy=0, oFinish=0.
//  - iEnable=0 (sync, iRst_n=1): same clear as reset except oZ holds its value; takes priority over all events.
//  - FSM states:
//    - IDLE: iStart moves to RUN, clears carry, count and oCarry.
//    - RUN: accepts one word per handshake.
//    - DRAIN: waits for the last output word to be taken.
//    - DONE: lasts one cycle; oFinish=1, then returns to IDLE.
//  - oReady = (state==RUN) && (!oValid || iReady). Single output register, no skid buffer.
//  - Accept (iValid && oReady):
//    - {c,sum} = iX + iY + carry, computed at W+1 bits.
//    - oZ <= sum; carry <= c; oValid <= 1; count <= count+1.
//  - Latency: 1 cycle from accept to oValid. Throughput is 1 word/cycle while iValid=iReady=1.
//  - oValid && iReady with no new accept: oValid <= 0. oZ is held stable while oValid && !iReady.
//  - Gaps with iValid=0 leave carry and count unchanged.
//  - Accepting word N_WORDS-1: oCarry <= c, state <= DRAIN. No further accepts.
//  - DRAIN: when oValid && iReady, move to DONE.
//  - iStart outside IDLE is ignored. iValid in IDLE/DRAIN/DONE is ignored (oReady=0).
//  - Wrap-around: the result is modulo 2^(W*N_WORDS); the overflow appears only on oCarry.
//  - Simultaneous iEnable=0 and any handshake: abort wins, and the word is dropped.
// STRUCTURE
//  - Package mp_arith_pkg: localparams W, N_WORDS, CW; state enum {IDLE,RUN,DRAIN,DONE}.
//    Shared with the subtractor.
//  - Sub-module mp_add_cell: combinational W-bit adder, inputs (a,b,cin), outputs (s,cout).
//    Reused in a future modular-add wrapper.
//  - Top module: FSM, counter, carry register, output register and handshake logic.
// TESTING
//  1. X=all 1s, Y=1 then zeros, iReady=1 -> 64 words of 0, oCarry=1, oFinish 1 cycle after last oValid.
//  2. X word0=5, Y word0=7, rest 0 -> word0=12, rest 0, oCarry=0, 64 oValid beats in 64 cycles.
//  3. Random operands, iReady toggling 50% -> oZ held under stall, no loss or duplication,
//     order LSW..MSW, sum matches model.
//  4. Random iValid gaps (word0 = 0xFFFFFFFF+1, carry pending) -> carry persists across gap, word1 = Xw1+Yw1+1.
//  5. iEnable=0 after word 20 accepted -> next cycle oValid=0, oBusy=0, IDLE;
//     a new iStart gives a clean result (carry=0).
//  6. 200 random 2048-bit vectors vs reference model; also feed the sum into the subtractor
//     with Y -> X recovered, borrow=oCarry.

Source files
------------

// File: rtl/mp_arith_pkg.sv
// mp_arith_pkg: shared word-serial big-number constants and FSM state type
package mp_arith_pkg;
  localparam int W       = 32;
  localparam int N_WORDS = 64;
  localparam int CW      = 7;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/mp_add_cell.sv
// mp_add_cell: combinational W-bit adder with carry in and carry out
module mp_add_cell
  import mp_arith_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/mp_add_serial.sv
// mp_add_serial: word-serial multi-precision adder, LSW first, valid/ready in, registered out
module mp_add_serial
  import mp_arith_pkg::*;
(
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iEnable,
  input  logic         iStart,
  input  logic [W-1:0] iX,
  input  logic [W-1:0] iY,
  input  logic         iValid,
  output logic         oReady,
  output logic [W-1:0] oZ,
  output logic         oValid,
  input  logic         iReady,
  output logic         oCarry,
  output logic         oBusy,
  output logic         oFinish
);
  state_t        r_state;
  logic          r_carry;
  logic [CW-1:0] r_count;
  logic [W-1:0]  w_sum;
  logic          w_cout;
  logic          w_accept;
  assign oReady   = (r_state == RUN) && (!oValid || iReady);
  assign w_accept = iValid && oReady;
  mp_add_cell u_cell (
    .a    (iX),
    .b    (iY),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout)
  );
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= IDLE;
      r_carry <= 1'b0;
      r_count <= '0;
      oZ      <= '0;
      oValid  <= 1'b0;
      oCarry  <= 1'b0;
      oBusy   <= 1'b0;
      oFinish <= 1'b0;
    end else if (!iEnable) begin
      r_state <= IDLE;
      r_carry <= 1'b0;
      r_count <= '0;
      oValid  <= 1'b0;
      oCarry  <= 1'b0;
      oBusy   <= 1'b0;
      oFinish <= 1'b0;
    end else begin
      oFinish <= 1'b0;
      if (oValid && iReady) oValid <= 1'b0;
      if (w_accept) begin
        oZ      <= w_sum;
        r_carry <= w_cout;
        oValid  <= 1'b1;
        r_count <= r_count + 1'b1;
        // last word: latch the overall carry-out and stop accepting
        if (r_count == CW'(N_WORDS - 1)) begin
          oCarry  <= w_cout;
          r_state <= DRAIN;
        end
      end
      case (r_state)
        IDLE: if (iStart) begin
          r_state <= RUN;
          r_carry <= 1'b0;
          r_count <= '0;
          oCarry  <= 1'b0;
          oBusy   <= 1'b1;
        end
        DRAIN: if (oValid && iReady) begin
          r_state <= DONE;
          oFinish <= 1'b1;
          oBusy   <= 1'b0;
        end
        DONE: r_state <= IDLE;
        default: ;
      endcase
    end
  end
endmodule
